// File: rtl/cue_sequencer.sv
// cue_sequencer: queued sound-cue player that steps a note ROM and drives
// the note index into the tone generator (node=0 is silence).
module cue_sequencer #(
    parameter int TICK_DIV = 5172414,
    parameter int GAP_DIV  = 250000,
    parameter int QDEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cue_valid,
    input  logic [1:0] cue_id,
    output logic       cue_ready,
    input  logic       cue_abort,
    output logic [3:0] node,
    output logic       busy,
    output logic [1:0] cur_cue,
    output logic       cue_done
);
    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(QDEPTH);
    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
    localparam logic [31:0] GAP_LAST = 32'(GAP_DIV - 1);
    localparam logic [7:0] ROM [4][8] = '{
        '{8'h81, 8'hA1, 8'hC1, 8'hF2, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h52, 8'h32, 8'h14, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'hC1, 8'hA1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h31, 8'h51, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}
    };

    typedef enum logic [1:0] {IDLE, LOAD, NOTE, GAP} state_t;
    state_t state, state_n;

    logic [1:0]  mem [QDEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic        empty, full, push, pop;
    logic [3:0]  idx, len_cnt;
    logic [31:0] unit_cnt, gap_cnt;
    logic [7:0]  entry;
    logic        term, note_end, gap_end;

    assign empty     = count == '0;
    assign full      = count == FULL;
    assign cue_ready = !full;
    assign busy      = state != IDLE;
    assign push      = cue_valid && !full && !cue_abort;
    assign pop       = state == IDLE && !empty && !cue_abort;

    always_comb begin
        entry    = idx[3] ? 8'h00 : ROM[cur_cue][idx[2:0]];
        term     = entry[3:0] == 4'd0;
        note_end = unit_cnt == TICK_LAST && len_cnt == 4'd1;
        gap_end  = gap_cnt == GAP_LAST;
        state_n  = cue_abort     ? IDLE :
                   state == IDLE ? (empty ? IDLE : LOAD) :
                   state == LOAD ? (term ? IDLE : NOTE) :
                   state == NOTE ? (note_end ? GAP : NOTE) :
                                   (gap_end ? LOAD : GAP);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cue_id;
    end

    // abort flushes the queue and outranks any same-cycle push or pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || cue_abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end

    // note length is len steps of TICK_DIV cycles: unit counter plus len down-counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            cur_cue  <= '0;
            node     <= '0;
            cue_done <= 1'b0;
            unit_cnt <= '0;
            len_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            cue_done <= !cue_abort && state == LOAD && term;
            if (cue_abort) begin
                node <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!empty) cur_cue <= mem[rd_ptr];
                        idx <= '0;
                    end
                    LOAD: begin
                        if (!term) node <= entry[7:4];
                        unit_cnt <= '0;
                        len_cnt  <= entry[3:0];
                        gap_cnt  <= '0;
                    end
                    NOTE: begin
                        if (unit_cnt == TICK_LAST) begin
                            unit_cnt <= '0;
                            len_cnt  <= len_cnt - 4'd1;
                            if (len_cnt == 4'd1) node <= '0;
                        end else begin
                            unit_cnt <= unit_cnt + 32'd1;
                        end
                    end
                    GAP: begin
                        if (gap_end) idx <= idx + 4'd1;
                        else gap_cnt <= gap_cnt + 32'd1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cue_sequencer.sv
// tb_cue_sequencer: directed checks of queueing, note timing, abort and reset
module tb_cue_sequencer;
    logic       clk, rst_n, cue_valid, cue_abort, cue_ready, busy, cue_done;
    logic [1:0] cue_id, cur_cue;
    logic [3:0] node;
    int n_checks = 0;
    int n_fail = 0;
    int nt [4][4] = '{'{8, 10, 12, 15}, '{5, 3, 1, 0}, '{12, 10, 0, 0}, '{3, 5, 0, 0}};
    int ln [4][4] = '{'{1, 1, 1, 2}, '{2, 2, 4, 0}, '{1, 1, 0, 0}, '{1, 1, 0, 0}};

    cue_sequencer #(.TICK_DIV(4), .GAP_DIV(2), .QDEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .cue_valid(cue_valid), .cue_id(cue_id),
        .cue_ready(cue_ready), .cue_abort(cue_abort), .node(node), .busy(busy),
        .cur_cue(cur_cue), .cue_done(cue_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // called just after the pop edge; walks the whole cue cycle by cycle
    task automatic expect_cue(input int id);
        for (int k = 0; k < 4; k++) begin
            if (ln[id][k] != 0) begin
                chk("load_node", node, 0);
                chk("load_busy", busy, 1);
                chk("cur_cue", cur_cue, id);
                step();
                repeat (ln[id][k] * 4) begin
                    chk("note", node, nt[id][k]);
                    chk("done_low", cue_done, 0);
                    step();
                end
                repeat (2) begin
                    chk("gap_node", node, 0);
                    chk("gap_busy", busy, 1);
                    step();
                end
            end
        end
        chk("end_load_node", node, 0);
        chk("end_load_busy", busy, 1);
        step();
        chk("cue_done", cue_done, 1);
        chk("idle_busy", busy, 0);
        chk("idle_node", node, 0);
    endtask

    task automatic wait_done(input int id);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            step();
            seen = cue_done;
        end
        chk("done_seen", seen, 1);
        chk("done_id", cur_cue, id);
        step();
        chk("done_pulse_1cyc", cue_done, 0);
    endtask

    initial begin
        rst_n = 1'b1; cue_valid = 1'b0; cue_id = 2'd0; cue_abort = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_node", node, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cue_ready, 1);
        chk("rst_done", cue_done, 0);
        chk("rst_cur_cue", cur_cue, 0);
        step();
        rst_n = 1'b1;
        step();

        // reset mid-note of cue1
        cue_valid = 1'b1; cue_id = 2'd1;
        step();
        cue_valid = 1'b0;
        repeat (5) step();
        chk("t1_pre_node", node, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_node", node, 0);
        chk("t1_busy", busy, 0);
        chk("t1_ready", cue_ready, 1);
        chk("t1_done", cue_done, 0);
        step();
        chk("t1_done_held", cue_done, 0);
        rst_n = 1'b1;
        repeat (20) begin
            step();
            chk("t1_stays_idle", busy, 0);
        end

        // single cue1 with full timing
        cue_valid = 1'b1; cue_id = 2'd1;
        step();
        cue_valid = 1'b0;
        chk("t2_e0_busy", busy, 0);
        chk("t2_e0_node", node, 0);
        step();
        expect_cue(1);
        step();
        chk("t2_after_done", cue_done, 0);
        chk("t2_after_busy", busy, 0);

        // five back-to-back pushes while idle
        cue_valid = 1'b1; cue_id = 2'd2;
        step();
        chk("t3_ready1", cue_ready, 1);
        cue_id = 2'd3;
        step();
        chk("t3_ready2", cue_ready, 1);
        cue_id = 2'd0;
        step();
        chk("t3_ready3", cue_ready, 1);
        cue_id = 2'd1;
        step();
        chk("t3_ready4", cue_ready, 1);
        cue_id = 2'd2;
        step();
        chk("t3_full", cue_ready, 0);
        cue_valid = 1'b0;
        wait_done(2);
        wait_done(3);
        wait_done(0);
        wait_done(1);
        wait_done(2);
        repeat (10) begin
            step();
            chk("t3_no_extra", busy, 0);
        end

        // push+pop keeps count; pushes while full dropped, even on a pop edge
        cue_valid = 1'b1; cue_id = 2'd3;
        step();
        cue_id = 2'd2;
        step();
        chk("t4_pushpop_ready", cue_ready, 1);
        cue_id = 2'd1;
        step();
        step();
        chk("t4_three", cue_ready, 1);
        step();
        chk("t4_full", cue_ready, 0);
        cue_id = 2'd0;
        step();
        chk("t4_full_hold", cue_ready, 0);
        wait_done(3);
        cue_valid = 1'b0;
        chk("t4_drop_on_pop", cue_ready, 1);
        wait_done(2);
        wait_done(1);
        wait_done(1);
        wait_done(1);
        repeat (10) begin
            step();
            chk("t4_no_cue0", busy, 0);
        end

        // abort during NOTE of cue0 with two cues queued
        cue_valid = 1'b1; cue_id = 2'd0;
        step();
        cue_id = 2'd1;
        step();
        cue_id = 2'd2;
        step();
        cue_valid = 1'b0;
        step();
        chk("t5_pre_node", node, 8);
        chk("t5_pre_ready", cue_ready, 1);
        cue_abort = 1'b1; cue_valid = 1'b1; cue_id = 2'd3;
        step();
        cue_abort = 1'b0; cue_valid = 1'b0;
        chk("t5_node", node, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", cue_done, 0);
        chk("t5_ready", cue_ready, 1);
        repeat (12) begin
            step();
            chk("t5_idle", busy, 0);
            chk("t5_no_done", cue_done, 0);
        end

        // cue3 then cue0 back-to-back
        cue_valid = 1'b1; cue_id = 2'd3;
        step();
        cue_id = 2'd0;
        step();
        cue_valid = 1'b0;
        expect_cue(3);
        step();
        expect_cue(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
